// File: rtl/pheap_host_ctrl.sv
// Purpose: host-side issuer for the pipelined priority heap; one op in flight, occupancy tracked against capacity.
// Latency: op on heap_op one cycle after accept; DEQ response / next accept two cycles after that at best.
// Backpressure: req_ready only in IDLE; responses held until rsp_ready; heap completion waited for without timeout.

package pheapTypes;

   typedef enum logic [1:0] {
      FREE  = 2'd0,
      LEQ   = 2'd1,
      DEQ   = 2'd2,
      CLEAR = 2'd3
   } opcode_t;

   // heap_done value 3 is not a named code and behaves like WAIT
   typedef enum logic [1:0] {
      DONE       = 2'd0,
      NEXT_LEVEL = 2'd1,
      WAIT       = 2'd2
   } done_t;

   typedef struct packed {
      opcode_t     levelOp;
      logic [31:0] priorityValue;
   } opArray_t;

endpackage

module pheap_host_ctrl
   import pheapTypes::*;
#(
   parameter int LEVELS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [31:0]       req_value,
   output logic [33:0]       heap_op,
   input  logic [1:0]        heap_done,
   input  logic [31:0]       heap_top,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_value,
   output logic              rsp_err,
   output logic [LEVELS:0]   count,
   output logic              full,
   output logic              empty,
   output logic              overflow
);

   localparam int             CAP_I = (1 << LEVELS) - 1;
   localparam logic [LEVELS:0] CAP  = CAP_I[LEVELS:0];
   localparam logic [LEVELS:0] ONE  = {{LEVELS{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_HEAP,
      S_RESP
   } state_t;

   state_t   state;
   opArray_t op_q;
   // remembers whether the outstanding heap op owes the host a response
   logic     is_deq;

   assign heap_op = op_q;

   // occupancy flags follow the committed count directly
   assign full  = (count == CAP);
   assign empty = (count == '0);

   // controller FSM; every output besides full/empty is a register here
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         op_q      <= '{levelOp: FREE, priorityValue: 32'd0};
         is_deq    <= 1'b0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_value <= 32'd0;
         rsp_err   <= 1'b0;
         count     <= '0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  case (req_op)
                     LEQ: begin
                        if (!full) begin
                           op_q      <= '{levelOp: LEQ, priorityValue: req_value};
                           count     <= count + ONE;
                           is_deq    <= 1'b0;
                           req_ready <= 1'b0;
                           state     <= S_ISSUE;
                        end else begin
                           // dropped: the heap must never see more than CAP entries
                           overflow <= 1'b1;
                        end
                     end
                     DEQ: begin
                        req_ready <= 1'b0;
                        if (!empty) begin
                           op_q   <= '{levelOp: DEQ, priorityValue: 32'd0};
                           count  <= count - ONE;
                           is_deq <= 1'b1;
                           state  <= S_ISSUE;
                        end else begin
                           // empty dequeue answered locally, heap untouched
                           rsp_value <= 32'd0;
                           rsp_err   <= 1'b1;
                           rsp_valid <= 1'b1;
                           state     <= S_RESP;
                        end
                     end
                     CLEAR: begin
                        op_q      <= '{levelOp: CLEAR, priorityValue: 32'd0};
                        count     <= '0;
                        overflow  <= 1'b0;
                        is_deq    <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= S_ISSUE;
                     end
                     default: begin
                        // FREE is accepted and discarded
                     end
                  endcase
               end
            end
            S_ISSUE: begin
               // the op is presented for exactly one cycle
               op_q  <= '{levelOp: FREE, priorityValue: 32'd0};
               state <= S_WAIT_HEAP;
            end
            S_WAIT_HEAP: begin
               if (heap_done == DONE || heap_done == NEXT_LEVEL) begin
                  if (is_deq) begin
                     rsp_value <= heap_top;
                     rsp_err   <= 1'b0;
                     rsp_valid <= 1'b1;
                     state     <= S_RESP;
                  end else begin
                     req_ready <= 1'b1;
                     state     <= S_IDLE;
                  end
               end
            end
            S_RESP: begin
               // value and error flag are left as-is after the handshake
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pheap_host_ctrl.sv
// Purpose: self-checking bench for pheap_host_ctrl; vector table, hand sequences, random ops vs a transaction model.
// Latency: expectations are stated in cycles after the accepting edge.
// Backpressure: the bench plays both the heap (done codes, wait cycles) and the host (delayed rsp_ready).

module tb_pheap_host_ctrl;

   localparam logic [1:0] OP_FREE  = 2'd0;
   localparam logic [1:0] OP_LEQ   = 2'd1;
   localparam logic [1:0] OP_DEQ   = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;
   localparam logic [1:0] D_DONE   = 2'd0;
   localparam logic [1:0] D_NEXT   = 2'd1;
   localparam logic [1:0] D_WAIT   = 2'd2;
   localparam int         CAP      = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_value;
   logic [33:0] heap_op;
   logic [1:0]  heap_done;
   logic [31:0] heap_top;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_value;
   logic        rsp_err;
   logic [4:0]  count;
   logic        full;
   logic        empty;
   logic        overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pheap_host_ctrl #(.LEVELS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_value (req_value),
      .heap_op   (heap_op),
      .heap_done (heap_done),
      .heap_top  (heap_top),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_value (rsp_value),
      .rsp_err   (rsp_err),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow)
   );

   typedef struct {
      int          nops;
      logic [33:0] op;
      int          rsp_k;
      logic [31:0] rsp_val;
      logic        rsp_err;
      int          ready_k;
      logic        unstable;
   } obs_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] val;
      int          wait_n;
      logic [1:0]  dcode;
      logic [31:0] top;
      int          hold;
      logic [33:0] e_op;
      int          e_nops;
      int          e_rsp_k;
      logic [31:0] e_rsp_val;
      logic        e_err;
      int          e_ready_k;
      int          e_count;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // One host transaction; cycle k is k cycles after the accepting edge.
   task automatic run_op(input logic [1:0] op, input logic [31:0] val, input int wait_n,
                         input logic [1:0] dcode, input logic [1:0] wcode,
                         input logic [31:0] top, input int hold, output obs_t o);
      int hold_left;
      bit got;
      o.nops = 0; o.op = '0; o.rsp_k = -1; o.rsp_val = '0; o.rsp_err = 1'b0;
      o.ready_k = -1; o.unstable = 1'b0;
      hold_left = 0;
      got = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = op; req_value = val; heap_top = top; heap_done = wcode;
      @(posedge clk); #1;
      req_valid = 1'b0; req_op = OP_FREE; req_value = '0;
      for (int k = 1; k <= 60; k++) begin
         heap_done = (k >= 2 && k - 2 == wait_n) ? dcode : wcode;
         rsp_ready = got && hold_left == 0;
         @(negedge clk);
         if (heap_op[33:32] != OP_FREE) begin
            o.nops++;
            if (o.nops == 1) o.op = heap_op;
         end
         if (rsp_valid) begin
            if (!got) begin
               got = 1'b1; o.rsp_k = k; o.rsp_val = rsp_value; o.rsp_err = rsp_err;
               hold_left = hold;
            end else begin
               if (rsp_value !== o.rsp_val || rsp_err !== o.rsp_err) o.unstable = 1'b1;
               if (hold_left > 0) hold_left--;
            end
         end
         if (req_ready) begin
            o.ready_k = k;
            break;
         end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b0;
      heap_done = wcode;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[11];
      obs_t o;
      int   occ;
      bit   ovf;
      int   heapq[$];
      int   acc;
      int   bad;

      rst = 1'b1; req_valid = 1'b0; req_op = OP_FREE; req_value = '0;
      heap_done = D_WAIT; heap_top = '0; rsp_ready = 1'b0;

      // reset state
      #12;
      chk("rst_heap_op",   heap_op,   34'h0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_value", rsp_value, 32'h0);
      chk("rst_rsp_err",   rsp_err,   1'b0);
      chk("rst_count",     count,     5'd0);
      chk("rst_overflow",  overflow,  1'b0);
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_empty",     empty,     1'b1);
      chk("rst_full",      full,      1'b0);
      #1 rst = 1'b0;

      //           op        val     wait dcode   top      hold e_op            nops rsp_k rsp_val  err  rdy cnt
      tbl[0]  = '{OP_LEQ,   32'h10, 0,   D_DONE, 32'h0,   0,   34'h1_0000_0010, 1,   -1,   32'h0,   1'b0, 3,  1};
      tbl[1]  = '{OP_LEQ,   32'h7,  1,   D_NEXT, 32'h0,   0,   34'h1_0000_0007, 1,   -1,   32'h0,   1'b0, 4,  2};
      tbl[2]  = '{OP_LEQ,   32'h3,  0,   D_DONE, 32'h0,   0,   34'h1_0000_0003, 1,   -1,   32'h0,   1'b0, 3,  3};
      tbl[3]  = '{OP_LEQ,   32'h9,  2,   D_DONE, 32'h0,   0,   34'h1_0000_0009, 1,   -1,   32'h0,   1'b0, 5,  4};
      tbl[4]  = '{OP_DEQ,   32'h0,  4,   D_NEXT, 32'h3,   3,   34'h2_0000_0000, 1,   7,    32'h3,   1'b0, 12, 3};
      tbl[5]  = '{OP_DEQ,   32'h0,  0,   D_DONE, 32'h7,   0,   34'h2_0000_0000, 1,   3,    32'h7,   1'b0, 5,  2};
      tbl[6]  = '{OP_DEQ,   32'h0,  1,   D_DONE, 32'h9,   1,   34'h2_0000_0000, 1,   4,    32'h9,   1'b0, 7,  1};
      tbl[7]  = '{OP_DEQ,   32'h0,  0,   D_NEXT, 32'h10,  0,   34'h2_0000_0000, 1,   3,    32'h10,  1'b0, 5,  0};
      tbl[8]  = '{OP_DEQ,   32'h0,  0,   D_DONE, 32'hDEAD,0,   34'h0,           0,   1,    32'h0,   1'b1, 3,  0};
      tbl[9]  = '{OP_CLEAR, 32'h55, 0,   D_DONE, 32'h0,   0,   34'h3_0000_0000, 1,   -1,   32'h0,   1'b0, 3,  0};
      tbl[10] = '{OP_FREE,  32'h77, 0,   D_DONE, 32'h0,   0,   34'h0,           0,   -1,   32'h0,   1'b0, 1,  0};

      foreach (tbl[i]) begin
         run_op(tbl[i].op, tbl[i].val, tbl[i].wait_n, tbl[i].dcode, D_WAIT, tbl[i].top, tbl[i].hold, o);
         chk($sformatf("vec%0d_op", i),      o.op,      tbl[i].e_op);
         chk($sformatf("vec%0d_nops", i),    o.nops,    tbl[i].e_nops);
         chk($sformatf("vec%0d_rsp_k", i),   o.rsp_k,   tbl[i].e_rsp_k);
         if (tbl[i].e_rsp_k >= 0) begin
            chk($sformatf("vec%0d_rsp_val", i), o.rsp_val, tbl[i].e_rsp_val);
            chk($sformatf("vec%0d_rsp_err", i), o.rsp_err, tbl[i].e_err);
            chk($sformatf("vec%0d_stable", i),  o.unstable, 1'b0);
         end
         chk($sformatf("vec%0d_ready_k", i), o.ready_k, tbl[i].e_ready_k);
         chk($sformatf("vec%0d_count", i),   count,     tbl[i].e_count);
      end

      // fill to capacity, then one more LEQ must be dropped
      for (int i = 0; i < CAP; i++) begin
         run_op(OP_LEQ, i + 1, 0, D_DONE, D_WAIT, 32'h0, 0, o);
         chk("fill_nops", o.nops, 1);
      end
      chk("fill_count", count, 5'd15);
      chk("fill_full",  full,  1'b1);
      chk("fill_empty", empty, 1'b0);
      run_op(OP_LEQ, 32'hFF, 0, D_DONE, D_WAIT, 32'h0, 0, o);
      chk("ovf_nops",     o.nops,    0);
      chk("ovf_ready_k",  o.ready_k, 1);
      chk("ovf_flag",     overflow,  1'b1);
      chk("ovf_count",    count,     5'd15);

      // back-to-back FREE requests are each accepted and do nothing
      acc = 0; bad = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = OP_FREE; req_value = 32'h1234;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (req_valid && req_ready) acc++;
         if (heap_op !== 34'h0) bad++;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      chk("free_accepts",  acc,   5);
      chk("free_heap_op",  bad,   0);
      chk("free_count",    count, 5'd15);

      run_op(OP_CLEAR, 32'h0, 1, D_DONE, D_WAIT, 32'h0, 0, o);
      chk("clr_op",       o.op,     34'h3_0000_0000);
      chk("clr_count",    count,    5'd0);
      chk("clr_overflow", overflow, 1'b0);
      chk("clr_empty",    empty,    1'b1);

      // random traffic against a transaction-level model
      occ = 0; ovf = 1'b0; heapq.delete();
      for (int n = 0; n < 200; n++) begin
         int          r, wait_n, hold, mi, e_nops, e_rsp_k, e_ready_k;
         logic [1:0]  op, dcode, wcode;
         logic [31:0] val, top, e_rsp_val;
         logic [33:0] e_op;
         logic        e_err;
         r = $urandom_range(0, 99);
         op = (r < 10) ? OP_FREE : (r < 55) ? OP_LEQ : (r < 94) ? OP_DEQ : OP_CLEAR;
         val = $urandom; wait_n = $urandom_range(0, 3); hold = $urandom_range(0, 2);
         dcode = 2'($urandom_range(0, 1)); wcode = 2'($urandom_range(2, 3));
         top = $urandom; mi = -1;
         if (heapq.size() > 0) begin
            mi = 0;
            foreach (heapq[j]) if (heapq[j] < heapq[mi]) mi = j;
            top = heapq[mi];
         end
         e_nops = 0; e_op = '0; e_rsp_k = -1; e_rsp_val = '0; e_err = 1'b0; e_ready_k = 1;
         case (op)
            OP_LEQ: if (occ < CAP) begin
               e_nops = 1; e_op = {OP_LEQ, val}; e_ready_k = 3 + wait_n;
               occ++; heapq.push_back(val);
            end else ovf = 1'b1;
            OP_DEQ: if (occ > 0) begin
               e_nops = 1; e_op = {OP_DEQ, 32'h0}; e_rsp_k = 3 + wait_n; e_rsp_val = top;
               e_ready_k = e_rsp_k + hold + 2; occ--; heapq.delete(mi);
            end else begin
               e_rsp_k = 1; e_err = 1'b1; e_ready_k = 3 + hold;
            end
            OP_CLEAR: begin
               e_nops = 1; e_op = {OP_CLEAR, 32'h0}; e_ready_k = 3 + wait_n;
               occ = 0; ovf = 1'b0; heapq.delete();
            end
            default: ;
         endcase
         run_op(op, val, wait_n, dcode, wcode, top, hold, o);
         chk("rnd_nops",    o.nops,    e_nops);
         chk("rnd_op",      o.op,      e_op);
         chk("rnd_rsp_k",   o.rsp_k,   e_rsp_k);
         if (e_rsp_k >= 0) begin
            chk("rnd_rsp_val", o.rsp_val,  e_rsp_val);
            chk("rnd_rsp_err", o.rsp_err,  e_err);
            chk("rnd_stable",  o.unstable, 1'b0);
         end
         chk("rnd_ready_k", o.ready_k, e_ready_k);
         chk("rnd_count",   count,     occ);
         chk("rnd_ovf",     overflow,  ovf);
         chk("rnd_full",    full,      occ == CAP);
         chk("rnd_empty",   empty,     occ == 0);
      end

      // reset while a DEQ waits on the heap
      run_op(OP_CLEAR, 32'h0, 0, D_DONE, D_WAIT, 32'h0, 0, o);
      run_op(OP_LEQ, 32'h42, 0, D_DONE, D_WAIT, 32'h0, 0, o);
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = OP_DEQ; heap_done = D_WAIT;
      @(posedge clk); #1;
      req_valid = 1'b0; req_op = OP_FREE;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_busy", req_ready, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("mid_heap_op",   heap_op,   34'h0);
      chk("mid_count",     count,     5'd0);
      chk("mid_rsp_valid", rsp_valid, 1'b0);
      chk("mid_req_ready", req_ready, 1'b1);
      #3 rst = 1'b0;
      heap_done = D_DONE; heap_top = 32'h55;
      acc = 0; bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid) acc++;
         if (!req_ready) bad++;
      end
      chk("post_rst_no_rsp", acc, 0);
      chk("post_rst_ready",  bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
